atm_pin_sequencer: RTL

Sequential PIN-entry controller for the ATM datapath. Collects up to four BCD keypad digits, checks them against a stored PIN, counts failed attempts and locks out after the limit. It sits directly upstream of the 16-to-1 4-bit display multiplexer. Its registered 4-bit status code drives the mux select lines S3..S0, which choose the message nibble shown to the user.

---
 rtl/atm_pin_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/atm_pin_sequencer.sv
// PIN-entry controller: buffers four BCD keypad digits, checks them against a stored PIN,
// counts failed attempts and locks out; the registered status code drives the display mux select.
module atm_pin_sequencer #(
    parameter logic [15:0] PIN         = 16'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       card_in,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       enter,
    input  logic       clear,
    output logic       s3,
    output logic       s2,
    output logic       s1,
    output logic       s0,
    output logic [2:0] digit_count,
    output logic       unlocked,
    output logic       locked
);

    localparam int unsigned DW = 4;
    localparam int unsigned BW = 16;
    localparam int unsigned CW = 3;
    localparam int unsigned AW = 3;
    localparam int unsigned HW = 8;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        GRANTED,
        DENIED,
        LOCKOUT
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] pin_buf, buf_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] tries, tries_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic [SW-1:0] code, code_nxt;
    logic          unlocked_q, unlocked_nxt;
    logic          locked_q, locked_nxt;

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pin_buf    <= '0;
            cnt        <= '0;
            tries      <= '0;
            hold       <= '0;
            code       <= '0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pin_buf    <= buf_nxt;
            cnt        <= cnt_nxt;
            tries      <= tries_nxt;
            hold       <= hold_nxt;
            code       <= code_nxt;
            unlocked_q <= unlocked_nxt;
            locked_q   <= locked_nxt;
        end
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_nxt    = state;
        buf_nxt      = pin_buf;
        cnt_nxt      = cnt;
        tries_nxt    = tries;
        hold_nxt     = hold;
        code_nxt     = '0;
        unlocked_nxt = 1'b0;
        locked_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (card_in) begin
                    state_nxt = ENTRY;
                    cnt_nxt   = '0;
                    buf_nxt   = '0;
                end
            end
            ENTRY: begin
                // Card removal outranks Clear, which outranks Enter, which outranks a key
                if (!card_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    buf_nxt   = '0;
                end else if (clear) begin
                    cnt_nxt = '0;
                    buf_nxt = '0;
                end else if (enter) begin
                    if (cnt == CW'(4)) state_nxt = CHECK;
                end else if (key_valid && (key <= 4'd9) && (cnt < CW'(4))) begin
                    buf_nxt = {pin_buf[BW-DW-1:0], key};
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CHECK: begin
                if (pin_buf == PIN) begin
                    state_nxt = GRANTED;
                    tries_nxt = '0;
                end else begin
                    tries_nxt = tries + AW'(1);
                    if (tries_nxt == AW'(MAX_TRIES)) begin
                        state_nxt = LOCKOUT;
                    end else begin
                        state_nxt = DENIED;
                        hold_nxt  = HW'(HOLD_CYCLES);
                    end
                end
            end
            GRANTED: begin
                if (!card_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    buf_nxt   = '0;
                end
            end
            DENIED: begin
                hold_nxt = hold - HW'(1);
                if (!card_in) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    cnt_nxt   = '0;
                    buf_nxt   = '0;
                end else if (hold_nxt == '0) begin
                    state_nxt = ENTRY;
                    cnt_nxt   = '0;
                    buf_nxt   = '0;
                end
            end
            LOCKOUT: begin
                state_nxt = LOCKOUT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        case (state_nxt)
            ENTRY:   code_nxt = SW'(cnt_nxt) + SW'(1);
            CHECK:   code_nxt = SW'(6);
            GRANTED: code_nxt = SW'(7);
            DENIED:  code_nxt = SW'(8);
            LOCKOUT: code_nxt = SW'(9);
            default: code_nxt = '0;
        endcase

        unlocked_nxt = (state_nxt == GRANTED);
        locked_nxt   = (state_nxt == LOCKOUT);
    end

    assign {s3, s2, s1, s0} = code;
    assign digit_count      = cnt;
    assign unlocked         = unlocked_q;
    assign locked           = locked_q;

endmodule
